// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared PCS types for the 1000BASE-X transmit path
package pcs_pkg;

  typedef enum logic [1:0] {
    XMIT_IDLE          = 2'd0,
    XMIT_CONFIGURATION = 2'd1,
    XMIT_DATA          = 2'd2
  } xmit_t;

  typedef enum logic [2:0] {
    OS_I, OS_C, OS_S, OS_D, OS_T, OS_R, OS_V, OS_LI
  } ordered_set_t;

  typedef enum logic [3:0] {
    ST_TX_TEST_XMIT,
    ST_CONFIGURATION,
    ST_IDLE,
    ST_XMIT_DATA,
    ST_START_OF_PACKET,
    ST_START_ERROR,
    ST_TX_DATA_ERROR,
    ST_TX_DATA,
    ST_END_OF_PACKET_NOEXT,
    ST_END_OF_PACKET_EXT,
    ST_EXTEND_BY_1,
    ST_CARRIER_EXTEND,
    ST_EPD2_NOEXT,
    ST_EPD3
  } tx_ordered_set_state_t;

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// rtl/pcs_tx_ordered_set.sv - PCS transmit ordered-set state machine
// Registered outputs take their entry value on the edge that enters the state.
module pcs_tx_ordered_set
  import pcs_pkg::*;
#(
  parameter logic [7:0] CARRIER_EXT_TXD = 8'h0F,
  parameter bit         SUPPORT_EXTEND  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  power_on,
  input  logic                  mr_main_reset,
  input  xmit_t                 xmit,
  input  logic                  TX_EN,
  input  logic                  TX_ER,
  input  logic [7:0]            TXD,
  input  logic                  TX_OSET_indicate,
  input  logic                  tx_even,
  input  logic                  receiving,
  output ordered_set_t          tx_o_set,
  output logic                  transmitting,
  output logic                  COL,
  output tx_ordered_set_state_t current_state,
  output logic                  state_change
);

  tx_ordered_set_state_t state, next_state, tx_packet;
  xmit_t                 xmit_ref;
  logic                  fire;
  logic                  xmit_change;

  function automatic ordered_set_t void_sel(input ordered_set_t os, input logic en,
                                            input logic er, input logic [7:0] txd);
    if ((en && er) || (!en && er && (txd != CARRIER_EXT_TXD))) return OS_V;
    return os;
  endfunction

  assign xmit_change   = (xmit != xmit_ref);
  assign current_state = state;

  // TX_PACKET decision point: resolved combinationally, never held in state
  always_comb begin
    if (TX_EN)                        tx_packet = TX_ER ? ST_TX_DATA_ERROR : ST_TX_DATA;
    else if (TX_ER && SUPPORT_EXTEND) tx_packet = ST_END_OF_PACKET_EXT;
    else                              tx_packet = ST_END_OF_PACKET_NOEXT;
  end

  // fire marks a (re)entry, the only time entry actions may update outputs
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    if (state != ST_TX_TEST_XMIT && xmit_change && TX_OSET_indicate && !tx_even) begin
      next_state = ST_TX_TEST_XMIT;
      fire       = 1'b1;
    end else begin
      case (state)
        ST_TX_TEST_XMIT: begin
          fire = 1'b1;
          if (xmit == XMIT_CONFIGURATION)                 next_state = ST_CONFIGURATION;
          else if (xmit == XMIT_DATA && !TX_EN && !TX_ER) next_state = ST_XMIT_DATA;
          else                                            next_state = ST_IDLE;
        end
        ST_CONFIGURATION: ;
        ST_IDLE: if (xmit == XMIT_DATA && TX_OSET_indicate && !TX_EN && !TX_ER) begin
          next_state = ST_XMIT_DATA;
          fire       = 1'b1;
        end
        ST_XMIT_DATA: if (TX_OSET_indicate && TX_EN) begin
          next_state = TX_ER ? ST_START_ERROR : ST_START_OF_PACKET;
          fire       = 1'b1;
        end
        ST_START_OF_PACKET, ST_TX_DATA_ERROR, ST_TX_DATA: if (TX_OSET_indicate) begin
          next_state = tx_packet;
          fire       = 1'b1;
        end
        ST_START_ERROR: if (TX_OSET_indicate) begin
          next_state = ST_TX_DATA_ERROR;
          fire       = 1'b1;
        end
        ST_END_OF_PACKET_NOEXT, ST_EXTEND_BY_1: if (TX_OSET_indicate) begin
          next_state = ST_EPD2_NOEXT;
          fire       = 1'b1;
        end
        ST_END_OF_PACKET_EXT: if (TX_OSET_indicate) begin
          next_state = TX_ER ? ST_CARRIER_EXTEND : ST_EXTEND_BY_1;
          fire       = 1'b1;
        end
        ST_CARRIER_EXTEND: if (TX_OSET_indicate) begin
          fire = 1'b1;
          if (!TX_ER) next_state = TX_EN ? ST_START_OF_PACKET : ST_EXTEND_BY_1;
          else        next_state = TX_EN ? ST_START_ERROR : ST_CARRIER_EXTEND;
        end
        ST_EPD2_NOEXT: if (TX_OSET_indicate) begin
          next_state = tx_even ? ST_EPD3 : ST_XMIT_DATA;
          fire       = 1'b1;
        end
        ST_EPD3: if (TX_OSET_indicate) begin
          next_state = ST_XMIT_DATA;
          fire       = 1'b1;
        end
        default: begin
          next_state = ST_TX_TEST_XMIT;
          fire       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_TX_TEST_XMIT;
      xmit_ref     <= XMIT_IDLE;
      tx_o_set     <= OS_I;
      transmitting <= 1'b0;
      COL          <= 1'b0;
      state_change <= 1'b0;
    end else if (power_on || mr_main_reset) begin
      state        <= ST_TX_TEST_XMIT;
      xmit_ref     <= XMIT_IDLE;
      tx_o_set     <= OS_I;
      transmitting <= 1'b0;
      COL          <= 1'b0;
      state_change <= 1'b0;
    end else begin
      state        <= next_state;
      state_change <= (next_state != state);
      if (state == ST_TX_TEST_XMIT) xmit_ref <= xmit;
      if (fire) begin
        case (next_state)
          ST_TX_TEST_XMIT:   transmitting <= 1'b0;
          ST_CONFIGURATION:  tx_o_set <= OS_C;
          ST_IDLE, ST_XMIT_DATA: tx_o_set <= OS_I;
          ST_START_OF_PACKET, ST_START_ERROR: begin
            tx_o_set     <= OS_S;
            transmitting <= 1'b1;
          end
          ST_TX_DATA_ERROR:  tx_o_set <= OS_V;
          ST_TX_DATA:        tx_o_set <= void_sel(OS_D, TX_EN, TX_ER, TXD);
          ST_END_OF_PACKET_NOEXT: begin
            tx_o_set <= OS_T;
            if (!tx_even) transmitting <= 1'b0;
          end
          ST_END_OF_PACKET_EXT: tx_o_set <= void_sel(OS_T, TX_EN, TX_ER, TXD);
          ST_EXTEND_BY_1: begin
            tx_o_set <= OS_R;
            if (!tx_even) transmitting <= 1'b0;
          end
          ST_CARRIER_EXTEND: tx_o_set <= void_sel(OS_R, TX_EN, TX_ER, TXD);
          ST_EPD2_NOEXT: begin
            tx_o_set     <= OS_R;
            transmitting <= 1'b0;
          end
          ST_EPD3:           tx_o_set <= OS_R;
          default: ;
        endcase
      end
      // collision tracks receiving continuously while a frame is on the wire
      case (next_state)
        ST_START_OF_PACKET, ST_START_ERROR, ST_TX_DATA_ERROR, ST_TX_DATA,
        ST_END_OF_PACKET_EXT, ST_CARRIER_EXTEND: COL <= receiving;
        ST_TX_TEST_XMIT, ST_END_OF_PACKET_NOEXT, ST_EXTEND_BY_1: COL <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// tb/tb_pcs_tx_ordered_set.sv - self-checking bench for pcs_tx_ordered_set
module tb_pcs_tx_ordered_set;
  import pcs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic power_on = 1'b0, mr_main_reset = 1'b0;
  xmit_t xmit = XMIT_DATA;
  logic TX_EN = 1'b0, TX_ER = 1'b0, TX_OSET_indicate = 1'b0, tx_even = 1'b0, receiving = 1'b0;
  logic [7:0] TXD = 8'h00;

  ordered_set_t tx_o_set, tx_o_set_n;
  logic transmitting, transmitting_n, COL, COL_n, state_change, state_change_n;
  tx_ordered_set_state_t current_state, current_state_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcs_tx_ordered_set dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .mr_main_reset(mr_main_reset),
    .xmit(xmit), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
    .TX_OSET_indicate(TX_OSET_indicate), .tx_even(tx_even), .receiving(receiving),
    .tx_o_set(tx_o_set), .transmitting(transmitting), .COL(COL),
    .current_state(current_state), .state_change(state_change)
  );

  pcs_tx_ordered_set #(.SUPPORT_EXTEND(1'b0)) dut_noext (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .mr_main_reset(mr_main_reset),
    .xmit(xmit), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
    .TX_OSET_indicate(TX_OSET_indicate), .tx_even(tx_even), .receiving(receiving),
    .tx_o_set(tx_o_set_n), .transmitting(transmitting_n), .COL(COL_n),
    .current_state(current_state_n), .state_change(state_change_n)
  );

  task automatic drive(input logic en, input logic er, input logic [7:0] d,
                       input logic ind, input logic ev, input logic rc);
    TX_EN = en; TX_ER = er; TXD = d; TX_OSET_indicate = ind; tx_even = ev; receiving = rc;
    @(posedge clk); #1;
    TX_OSET_indicate = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (current_state !== ST_TX_TEST_XMIT) begin errors++; $display("FAIL reset_state: got %0d exp %0d", current_state, ST_TX_TEST_XMIT); end
    checks++; if (tx_o_set !== OS_I) begin errors++; $display("FAIL reset_os: got %0d exp %0d", tx_o_set, OS_I); end
    checks++; if (transmitting !== 1'b0) begin errors++; $display("FAIL reset_tx: got %0b exp 0", transmitting); end
    checks++; if (COL !== 1'b0) begin errors++; $display("FAIL reset_col: got %0b exp 0", COL); end
    checks++; if (state_change !== 1'b0) begin errors++; $display("FAIL reset_chg: got %0b exp 0", state_change); end
    rst_n = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (current_state !== ST_XMIT_DATA) begin errors++; $display("FAIL rel_state: got %0d exp %0d", current_state, ST_XMIT_DATA); end
    checks++; if (state_change !== 1'b1) begin errors++; $display("FAIL rel_chg: got %0b exp 1", state_change); end
    checks++; if (tx_o_set !== OS_I) begin errors++; $display("FAIL rel_os: got %0d exp %0d", tx_o_set, OS_I); end
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (state_change !== 1'b0) begin errors++; $display("FAIL rel_chg2: got %0b exp 0", state_change); end
  endtask

  // Frame model: S, then D or V per byte, T, R, optional second R on an even EPD2, then I.
  task automatic test_frames();
    logic [9:0] en_v, er_v, ev_v, rc_v;
    ordered_set_t exp_os, last_os;
    logic exp_tr, exp_col, p_en, p_er, p_ev, p_rc;
    logic [7:0] d;
    last_os = OS_I; p_en = 0; p_er = 0; p_ev = 0; p_rc = 0;
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < 10; k++) begin
        en_v[k] = (k < n);
        er_v[k] = (k > 0 && k < n) ? ($urandom_range(0, 3) == 0) : 1'b0;
        ev_v[k] = 1'($urandom_range(0, 1));
        rc_v[k] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < n + 4; k++) begin
        int gap;
        if (k == 0)          exp_os = OS_S;
        else if (k < n)      exp_os = er_v[k] ? OS_V : OS_D;
        else if (k == n)     exp_os = OS_T;
        else if (k == n + 1) exp_os = OS_R;
        else if (k == n + 2) exp_os = ev_v[k] ? OS_R : OS_I;
        else                 exp_os = OS_I;
        exp_tr  = (k < n) ? 1'b1 : (k == n) ? ev_v[n] : 1'b0;
        exp_col = (k < n) ? rc_v[k] : 1'b0;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          drive(p_en, p_er, 8'h00, 0, p_ev, p_rc);
          checks++; if (tx_o_set !== last_os) begin errors++; $display("FAIL gap_os f%0d k%0d: got %0d exp %0d", f, k, tx_o_set, last_os); end
        end
        d = 8'($urandom);
        drive(en_v[k], er_v[k], d, 1, ev_v[k], rc_v[k]);
        checks++; if (tx_o_set !== exp_os) begin errors++; $display("FAIL frame_os f%0d k%0d: got %0d exp %0d", f, k, tx_o_set, exp_os); end
        checks++; if (transmitting !== exp_tr) begin errors++; $display("FAIL frame_tx f%0d k%0d: got %0b exp %0b", f, k, transmitting, exp_tr); end
        checks++; if (COL !== exp_col) begin errors++; $display("FAIL frame_col f%0d k%0d: got %0b exp %0b", f, k, COL, exp_col); end
        last_os = exp_os; p_en = en_v[k]; p_er = er_v[k]; p_ev = ev_v[k]; p_rc = rc_v[k];
      end
    end
  endtask

  task automatic test_errors();
    ordered_set_t exp_a [7] = '{OS_S, OS_D, OS_V, OS_D, OS_T, OS_R, OS_I};
    ordered_set_t exp_b [6] = '{OS_S, OS_V, OS_D, OS_T, OS_R, OS_I};
    logic [6:0] en_a = 7'b0001111, er_a = 7'b0000100;
    logic [5:0] en_b = 6'b000111, er_b = 6'b000001;
    for (int k = 0; k < 7; k++) begin
      drive(en_a[k], er_a[k], 8'h55, 1, 0, 0);
      checks++; if (tx_o_set !== exp_a[k]) begin errors++; $display("FAIL mid_err_os k%0d: got %0d exp %0d", k, tx_o_set, exp_a[k]); end
    end
    for (int k = 0; k < 6; k++) begin
      drive(en_b[k], er_b[k], 8'h55, 1, 0, 0);
      checks++; if (tx_o_set !== exp_b[k]) begin errors++; $display("FAIL start_err_os k%0d: got %0d exp %0d", k, tx_o_set, exp_b[k]); end
      if (k == 0) begin
        checks++; if (current_state !== ST_START_ERROR) begin errors++; $display("FAIL start_err_state: got %0d exp %0d", current_state, ST_START_ERROR); end
      end
      if (k == 3) begin
        checks++; if (transmitting !== 1'b0) begin errors++; $display("FAIL start_err_tx_end: got %0b exp 0", transmitting); end
      end
    end
  endtask

  task automatic test_extend();
    ordered_set_t exp_e [8] = '{OS_S, OS_D, OS_T, OS_R, OS_V, OS_R, OS_R, OS_I};
    ordered_set_t exp_n [8] = '{OS_S, OS_D, OS_T, OS_R, OS_I, OS_I, OS_I, OS_I};
    logic [7:0] en_e = 8'b00000011, er_e = 8'b00011100, tr_e = 8'b00011111;
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      d = (k == 4) ? 8'h1F : 8'h0F;
      drive(en_e[k], er_e[k], d, 1, 0, 0);
      checks++; if (tx_o_set !== exp_e[k]) begin errors++; $display("FAIL ext_os k%0d: got %0d exp %0d", k, tx_o_set, exp_e[k]); end
      checks++; if (tx_o_set_n !== exp_n[k]) begin errors++; $display("FAIL noext_os k%0d: got %0d exp %0d", k, tx_o_set_n, exp_n[k]); end
      checks++; if (transmitting !== tr_e[k]) begin errors++; $display("FAIL ext_tx k%0d: got %0b exp %0b", k, transmitting, tr_e[k]); end
    end
  endtask

  task automatic test_xmit_change();
    xmit = XMIT_IDLE;
    drive(0, 0, 8'h00, 1, 0, 0);
    checks++; if (current_state !== ST_TX_TEST_XMIT) begin errors++; $display("FAIL xc_to_test: got %0d exp %0d", current_state, ST_TX_TEST_XMIT); end
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (current_state !== ST_IDLE) begin errors++; $display("FAIL xc_idle: got %0d exp %0d", current_state, ST_IDLE); end
    xmit = XMIT_CONFIGURATION;
    drive(0, 0, 8'h00, 1, 1, 0);
    checks++; if (current_state !== ST_IDLE) begin errors++; $display("FAIL xc_even_hold: got %0d exp %0d", current_state, ST_IDLE); end
    drive(0, 0, 8'h00, 1, 0, 0);
    checks++; if (current_state !== ST_TX_TEST_XMIT) begin errors++; $display("FAIL xc_odd_test: got %0d exp %0d", current_state, ST_TX_TEST_XMIT); end
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (current_state !== ST_CONFIGURATION) begin errors++; $display("FAIL xc_conf: got %0d exp %0d", current_state, ST_CONFIGURATION); end
    checks++; if (tx_o_set !== OS_C) begin errors++; $display("FAIL xc_conf_os: got %0d exp %0d", tx_o_set, OS_C); end
    drive(0, 0, 8'h00, 1, 1, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    checks++; if (current_state !== ST_CONFIGURATION) begin errors++; $display("FAIL xc_conf_stay: got %0d exp %0d", current_state, ST_CONFIGURATION); end
    checks++; if (state_change !== 1'b0) begin errors++; $display("FAIL xc_conf_chg: got %0b exp 0", state_change); end
    xmit = XMIT_DATA;
    drive(0, 0, 8'h00, 1, 0, 0);
    checks++; if (tx_o_set !== OS_C) begin errors++; $display("FAIL xc_test_hold_os: got %0d exp %0d", tx_o_set, OS_C); end
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (current_state !== ST_XMIT_DATA) begin errors++; $display("FAIL xc_back_data: got %0d exp %0d", current_state, ST_XMIT_DATA); end
    checks++; if (tx_o_set !== OS_I) begin errors++; $display("FAIL xc_back_os: got %0d exp %0d", tx_o_set, OS_I); end
  endtask

  task automatic test_col_reset();
    drive(1, 0, 8'h00, 1, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    checks++; if (tx_o_set !== OS_D) begin errors++; $display("FAIL cr_data: got %0d exp %0d", tx_o_set, OS_D); end
    drive(1, 0, 8'h00, 0, 0, 1);
    checks++; if (COL !== 1'b1) begin errors++; $display("FAIL cr_col_rise: got %0b exp 1", COL); end
    drive(1, 0, 8'h00, 0, 0, 0);
    checks++; if (COL !== 1'b0) begin errors++; $display("FAIL cr_col_fall: got %0b exp 0", COL); end
    mr_main_reset = 1'b1;
    drive(1, 0, 8'h00, 0, 0, 1);
    mr_main_reset = 1'b0;
    checks++; if (current_state !== ST_TX_TEST_XMIT) begin errors++; $display("FAIL cr_mr_state: got %0d exp %0d", current_state, ST_TX_TEST_XMIT); end
    checks++; if (transmitting !== 1'b0) begin errors++; $display("FAIL cr_mr_tx: got %0b exp 0", transmitting); end
    checks++; if (COL !== 1'b0) begin errors++; $display("FAIL cr_mr_col: got %0b exp 0", COL); end
    checks++; if (tx_o_set !== OS_I) begin errors++; $display("FAIL cr_mr_os: got %0d exp %0d", tx_o_set, OS_I); end
    drive(0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    checks++; if (transmitting !== 1'b1) begin errors++; $display("FAIL cr_po_start: got %0b exp 1", transmitting); end
    power_on = 1'b1;
    drive(1, 0, 8'h00, 1, 0, 0);
    power_on = 1'b0;
    checks++; if (current_state !== ST_TX_TEST_XMIT) begin errors++; $display("FAIL cr_po_state: got %0d exp %0d", current_state, ST_TX_TEST_XMIT); end
    checks++; if (transmitting !== 1'b0) begin errors++; $display("FAIL cr_po_tx: got %0b exp 0", transmitting); end
    drive(0, 0, 8'h00, 0, 0, 0);
    checks++; if (current_state !== ST_XMIT_DATA) begin errors++; $display("FAIL cr_po_back: got %0d exp %0d", current_state, ST_XMIT_DATA); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_errors();
    test_extend();
    test_xmit_change();
    test_col_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_tx_ordered_set.md
Name: pcs_tx_ordered_set

Overview:
PCS transmit ordered-set state machine from IEEE 802.3-2022 Clause 36, Figure 36-5. It sits directly upstream of the transmit code-group state machine. It turns GMII TX_EN/TX_ER/TXD and the auto-negotiation xmit control into tx_o_set, and advances on the TX_OSET_indicate pulse returned by that stage. It also drives the GMII-side transmitting and COL signals.

Parameters:
CARRIER_EXT_TXD, 8'h0F, TXD value that marks valid carrier extension while TX_EN=0 and TX_ER=1.
SUPPORT_EXTEND, 1, 1 enables the carrier-extension path; 0 treats end-of-packet with TX_ER=1 as the no-extension end.

Ports:
clk  in  1  PCS clock
rst_n  in  1  asynchronous active-low reset
power_on  in  1  global reset condition, ORed with mr_main_reset
mr_main_reset  in  1  management reset
xmit  in  xmit_t  XMIT_IDLE / XMIT_CONFIGURATION / XMIT_DATA, from auto-negotiation
TX_EN  in  1  GMII transmit enable
TX_ER  in  1  GMII transmit error
TXD  in  8  GMII data; used only to qualify carrier extend
TX_OSET_indicate  in  1  one-cycle pulse from code-group SM: current ordered set consumed
tx_even  in  1  code-group SM even/odd alignment
receiving  in  1  from receive SM, used for collision
tx_o_set  out  ordered_set_t  ordered set requested from the code-group SM
transmitting  out  1  GMII-side transmit activity
COL  out  1  collision indication
current_state  out  tx_ordered_set_state_t  debug
state_change  out  1  registered flag: state changed on the last edge

Behaviour:
- Reset values, and values under power_on|mr_main_reset (synchronous override, highest priority):
  - state = TX_TEST_XMIT
  - tx_o_set = OS_I
  - transmitting = 0, COL = 0, state_change = 0
- Timing: state and all outputs are registered. Outputs are computed from next_state, so they take their new value on the same edge the state is entered. tx_o_set changes only on an edge where TX_OSET_indicate=1, or on a forced transition.
- xmitCHANGE:
  - xmit_ref is loaded with xmit every cycle the state is TX_TEST_XMIT.
  - xmitCHANGE = (xmit != xmit_ref).
  - In any state other than TX_TEST_XMIT, the condition xmitCHANGE & TX_OSET_indicate & !tx_even forces the state to TX_TEST_XMIT. This has second priority, after reset.
- VOID(x) is /V/ when either of these holds, otherwise it is x:
  - TX_EN & TX_ER
  - !TX_EN & TX_ER & (TXD != CARRIER_EXT_TXD)
- TX_PACKET is a combinational decision point, never a registered state. It selects, in this order:
  - TX_EN & !TX_ER -> TX_DATA
  - TX_EN & TX_ER -> TX_DATA_ERROR
  - !TX_EN & !TX_ER -> END_OF_PACKET_NOEXT
  - !TX_EN & TX_ER -> END_OF_PACKET_EXT, or END_OF_PACKET_NOEXT if SUPPORT_EXTEND=0
- States (entry actions; "ind" = TX_OSET_indicate):
  - TX_TEST_XMIT: transmitting=0, COL=0. Next state:
    - xmit=CONFIGURATION -> CONFIGURATION
    - xmit=IDLE, or xmit=DATA & (TX_EN|TX_ER) -> IDLE
    - xmit=DATA & !TX_EN & !TX_ER -> XMIT_DATA
  - CONFIGURATION: tx_o_set=OS_C. Leaves only via xmitCHANGE.
  - IDLE: tx_o_set=OS_I. xmit=DATA & ind & !TX_EN & !TX_ER -> XMIT_DATA.
  - XMIT_DATA: tx_o_set=OS_I. On ind:
    - TX_EN & !TX_ER -> START_OF_PACKET
    - TX_EN & TX_ER -> START_ERROR
  - START_OF_PACKET: transmitting=1, COL=receiving, tx_o_set=OS_S. ind -> TX_PACKET.
  - START_ERROR: transmitting=1, COL=receiving, tx_o_set=OS_S. ind -> TX_DATA_ERROR.
  - TX_DATA_ERROR: COL=receiving, tx_o_set=OS_V. ind -> TX_PACKET.
  - TX_DATA: COL=receiving, tx_o_set=VOID(OS_D). ind -> TX_PACKET.
  - END_OF_PACKET_NOEXT: transmitting=0 if !tx_even; COL=0; tx_o_set=OS_T. ind -> EPD2_NOEXT.
  - END_OF_PACKET_EXT: COL=receiving, tx_o_set=VOID(OS_T). On ind:
    - !TX_ER -> EXTEND_BY_1
    - TX_ER -> CARRIER_EXTEND
  - EXTEND_BY_1: transmitting=0 if !tx_even; COL=0; tx_o_set=OS_R. ind -> EPD2_NOEXT.
  - CARRIER_EXTEND: COL=receiving, tx_o_set=VOID(OS_R). On ind:
    - !TX_EN & !TX_ER -> EXTEND_BY_1
    - TX_EN & !TX_ER -> START_OF_PACKET
    - TX_EN & TX_ER -> START_ERROR
  - EPD2_NOEXT: transmitting=0, tx_o_set=OS_R. On ind:
    - !tx_even -> XMIT_DATA
    - tx_even -> EPD3
  - EPD3: tx_o_set=OS_R. ind -> XMIT_DATA.
- COL=receiving is re-evaluated every cycle while in START_OF_PACKET, START_ERROR, TX_DATA_ERROR, TX_DATA, END_OF_PACKET_EXT and CARRIER_EXTEND.
- Not generated: OS_LI (EEE not supported) and ALIGN_ERR_START. An unknown state value -> TX_TEST_XMIT.

Decomposition:
- pcs_pkg: tx_ordered_set_state_t and xmit_t. ordered_set_t is reused from pcs_pkg.
- VOID selection is a local function in this module.
- No sub-module: single state register plus next-state/output logic.

Test Plan:
- Reset release, xmit=XMIT_DATA, TX_EN=0 -> TX_TEST_XMIT then XMIT_DATA; tx_o_set=OS_I; transmitting=0.
- TX_EN=1 for 3 ind pulses, then TX_EN=0 with tx_even=1 at EPD2 -> sequence S,D,D,T,R,R,I. transmitting rises with S and falls at T/R on an ind with tx_even=0.
- TX_ER=1 for one ind mid-frame -> S,D,V,D; TX_EN=1 & TX_ER=1 at start -> S,V,D.
- End of packet with TX_ER=1, TXD=8'h0F for 2 ind, then TXD=8'h1F -> T,R,V, then EXTEND_BY_1 R, EPD2 R; with SUPPORT_EXTEND=0 -> T,R.
- In IDLE, xmit->XMIT_CONFIGURATION: ind with tx_even=1 -> no change; ind with tx_even=0 -> TX_TEST_XMIT, then CONFIGURATION, tx_o_set=OS_C.
- receiving=1 during TX_DATA -> COL=1 on the next edge. Assert mr_main_reset mid-frame -> TX_TEST_XMIT, transmitting=0, COL=0 next edge.
